overlay_blend_pipe: RTL and testbench

- Pipelined, multi-channel successor to the single-layer overlay.
- Alpha-blends a streamed overlay window onto the base pixel stream, with these additions:
  - parametrised channel count
  - rounded blend arithmetic
  - global (plane) alpha
  - colour-key transparency
  - an overlay-valid handshake with underflow flag
  - frame-synchronous shadowing of all configuration
- Sits inline in the imager datapath between the colour-processing stages and the output formatter.

---
 rtl/overlay_blend_pipe.sv | 272 +++++++++++++++++++++++++++
 tb/tb_overlay_blend_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_blend_pipe.sv
// overlay_blend_pipe: two-stage alpha blender that composites a streamed
// overlay window onto the base pixel stream.
//
// Ports
//   clk, reset              pixel clock, synchronous active-high reset
//   enable .. key_value     configuration, captured at each frame start
//   overlay_data/overlayA   overlay pixel and its alpha, qualified by
//   overlay_valid           overlay_valid
//   overlay_adv             pulse: one overlay pixel consumed
//   overlay_restart         pulse: overlay source should rewind
//   overlay_underflow       sticky: window pixel arrived without overlay
//   dvi/dtypei/datai/       input word (valid, type, base pixel, meta)
//   meta_datai
//   dvo/dtypeo/datao/       output word, two cycles after the input
//   meta_datao

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL (`DTYPE_WIDTH'(1))
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START (`DTYPE_WIDTH'(2))
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END (`DTYPE_WIDTH'(3))
`endif

module overlay_blend_pipe #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int ALPHA_WIDTH  = 8,
    parameter int NUM_CHANNELS = 3,
    parameter int DATA_WIDTH   = 16,
    parameter int DIM_WIDTH    = 11
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [DIM_WIDTH-1:0]                col_start,
    input  logic [DIM_WIDTH-1:0]                row_start,
    input  logic [DIM_WIDTH-1:0]                num_overlay_cols,
    input  logic [DIM_WIDTH-1:0]                num_overlay_rows,
    input  logic [ALPHA_WIDTH-1:0]              global_alpha,
    input  logic                                key_enable,
    input  logic [NUM_CHANNELS*PIXEL_WIDTH-1:0] key_value,
    input  logic [NUM_CHANNELS*PIXEL_WIDTH-1:0] overlay_data,
    input  logic [ALPHA_WIDTH-1:0]              overlayA,
    input  logic                                overlay_valid,
    output logic                                overlay_adv,
    output logic                                overlay_restart,
    output logic                                overlay_underflow,
    input  logic                                dvi,
    input  logic [`DTYPE_WIDTH-1:0]             dtypei,
    input  logic [NUM_CHANNELS*PIXEL_WIDTH-1:0] datai,
    input  logic [DATA_WIDTH-1:0]               meta_datai,
    output logic                                dvo,
    output logic [`DTYPE_WIDTH-1:0]             dtypeo,
    output logic [NUM_CHANNELS*PIXEL_WIDTH-1:0] datao,
    output logic [DATA_WIDTH-1:0]               meta_datao
);

    localparam int CW = NUM_CHANNELS * PIXEL_WIDTH;
    localparam int SW = 2 * ALPHA_WIDTH + 1;
    localparam int BW = PIXEL_WIDTH + ALPHA_WIDTH + 1;

    localparam logic [ALPHA_WIDTH-1:0] A_MAX  = '1;
    localparam logic [SW-1:0]          S_HALF = SW'(1) << (ALPHA_WIDTH - 1);
    localparam logic [BW-1:0]          B_HALF = BW'(1) << (ALPHA_WIDTH - 1);

    // ---------------- configuration shadows ----------------
    logic                   en_sh_q;
    logic [DIM_WIDTH-1:0]   cs_sh_q;
    logic [DIM_WIDTH-1:0]   rs_sh_q;
    logic [DIM_WIDTH-1:0]   nc_sh_q;
    logic [DIM_WIDTH-1:0]   nr_sh_q;
    logic [ALPHA_WIDTH-1:0] ga_sh_q;
    logic                   key_en_sh_q;
    logic [CW-1:0]          key_sh_q;

    // ---------------- stage 0 state ----------------
    logic [DIM_WIDTH-1:0] row_pos_q, row_pos_d;
    logic [DIM_WIDTH-1:0] col_pos_q, col_pos_d;
    logic                 adv_q, adv_d;
    logic                 restart_q, restart_d;
    logic                 underflow_q, underflow_d;

    // ---------------- stage 1 registers ----------------
    logic                    s1_dv_q;
    logic [`DTYPE_WIDTH-1:0] s1_dtype_q;
    logic [DATA_WIDTH-1:0]   s1_meta_q;
    logic [CW-1:0]           s1_base_q;
    logic [CW-1:0]           s1_ov_q;
    logic [ALPHA_WIDTH-1:0]  s1_ea_q, ea_d;
    logic                    s1_win_q;

    // ---------------- stage 2 registers ----------------
    logic                    dvo_q;
    logic [`DTYPE_WIDTH-1:0] dtype_q;
    logic [CW-1:0]           data_q, blend_d;
    logic [DATA_WIDTH-1:0]   meta_q;

    // ---------------- word decode ----------------
    logic is_fs, is_re, is_px;

    assign is_fs = dvi && (dtypei == `DTYPE_FRAME_START);
    assign is_re = dvi && (dtypei == `DTYPE_ROW_END);
    assign is_px = dvi && (dtypei == `DTYPE_PIXEL);

    // ---------------- window test ----------------
    // Ends are one bit wider so a window running off the frame clips
    // instead of wrapping back to coordinate 0.
    logic [DIM_WIDTH:0] row_end, col_end;
    logic               in_win;

    assign row_end = {1'b0, rs_sh_q} + {1'b0, nr_sh_q};
    assign col_end = {1'b0, cs_sh_q} + {1'b0, nc_sh_q};

    assign in_win = is_px && en_sh_q
                 && (row_pos_q >= rs_sh_q)
                 && ({1'b0, row_pos_q} < row_end)
                 && (col_pos_q >= cs_sh_q)
                 && ({1'b0, col_pos_q} < col_end);

    // ---------------- position counters ----------------
    always_comb begin
        row_pos_d = row_pos_q;
        col_pos_d = col_pos_q;
        unique case (1'b1)
            is_fs: begin
                row_pos_d = '0;
                col_pos_d = '0;
            end
            is_re: begin
                row_pos_d = row_pos_q + 1'b1;
                col_pos_d = '0;
            end
            is_px: begin
                col_pos_d = col_pos_q + 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- effective alpha ----------------
    logic          keyed;
    logic [SW-1:0] scaled;

    assign keyed  = key_en_sh_q && (overlay_data == key_sh_q);
    assign scaled = SW'(overlayA) * SW'(ga_sh_q) + S_HALF;

    always_comb begin
        ea_d = '0;
        if (in_win && overlay_valid && !keyed) begin
            // An all-ones plane alpha bypasses scaling so opaque stays opaque.
            if (ga_sh_q == A_MAX) begin
                ea_d = overlayA;
            end else begin
                ea_d = ALPHA_WIDTH'(scaled >> ALPHA_WIDTH);
            end
        end
    end

    // ---------------- overlay handshake ----------------
    always_comb begin
        adv_d       = in_win && overlay_valid;
        restart_d   = is_fs && enable;
        underflow_d = underflow_q;
        if (is_fs) begin
            underflow_d = 1'b0;
        end else if (in_win && !overlay_valid) begin
            underflow_d = 1'b1;
        end
    end

    // ---------------- stage 0 -> 1 ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            en_sh_q     <= 1'b0;
            cs_sh_q     <= '0;
            rs_sh_q     <= '0;
            nc_sh_q     <= '0;
            nr_sh_q     <= '0;
            ga_sh_q     <= '0;
            key_en_sh_q <= 1'b0;
            key_sh_q    <= '0;
            row_pos_q   <= '0;
            col_pos_q   <= '0;
            adv_q       <= 1'b0;
            restart_q   <= 1'b0;
            underflow_q <= 1'b0;
            s1_dv_q     <= 1'b0;
            s1_dtype_q  <= '0;
            s1_meta_q   <= '0;
            s1_base_q   <= '0;
            s1_ov_q     <= '0;
            s1_ea_q     <= '0;
            s1_win_q    <= 1'b0;
        end else begin
            if (is_fs) begin
                en_sh_q     <= enable;
                cs_sh_q     <= col_start;
                rs_sh_q     <= row_start;
                nc_sh_q     <= num_overlay_cols;
                nr_sh_q     <= num_overlay_rows;
                ga_sh_q     <= global_alpha;
                key_en_sh_q <= key_enable;
                key_sh_q    <= key_value;
            end
            row_pos_q   <= row_pos_d;
            col_pos_q   <= col_pos_d;
            adv_q       <= adv_d;
            restart_q   <= restart_d;
            underflow_q <= underflow_d;
            s1_dv_q     <= dvi;
            s1_dtype_q  <= dtypei;
            s1_meta_q   <= meta_datai;
            s1_base_q   <= datai;
            s1_ov_q     <= overlay_data;
            s1_ea_q     <= ea_d;
            s1_win_q    <= in_win;
        end
    end

    // ---------------- stage 1 -> 2 blend ----------------
    // Rounded blend against M = 2^ALPHA_WIDTH-1; the two end points are
    // special-cased because the rounded formula misses full-scale by one.
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic [PIXEL_WIDTH-1:0] ov_c;
        logic [PIXEL_WIDTH-1:0] base_c;
        logic [BW-1:0]          acc;

        assign ov_c   = s1_ov_q[g*PIXEL_WIDTH +: PIXEL_WIDTH];
        assign base_c = s1_base_q[g*PIXEL_WIDTH +: PIXEL_WIDTH];
        assign acc    = BW'(s1_ea_q) * BW'(ov_c)
                      + BW'(A_MAX - s1_ea_q) * BW'(base_c)
                      + B_HALF;

        always_comb begin
            blend_d[g*PIXEL_WIDTH +: PIXEL_WIDTH] = base_c;
            if (s1_win_q && s1_ea_q == A_MAX) begin
                blend_d[g*PIXEL_WIDTH +: PIXEL_WIDTH] = ov_c;
            end else if (s1_win_q && s1_ea_q != '0) begin
                blend_d[g*PIXEL_WIDTH +: PIXEL_WIDTH] =
                    PIXEL_WIDTH'(acc >> ALPHA_WIDTH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvo_q   <= 1'b0;
            dtype_q <= '0;
            data_q  <= '0;
            meta_q  <= '0;
        end else begin
            dvo_q   <= s1_dv_q;
            dtype_q <= s1_dtype_q;
            data_q  <= blend_d;
            meta_q  <= s1_meta_q;
        end
    end

    assign dvo               = dvo_q;
    assign dtypeo            = dtype_q;
    assign datao             = data_q;
    assign meta_datao        = meta_q;
    assign overlay_adv       = adv_q;
    assign overlay_restart   = restart_q;
    assign overlay_underflow = underflow_q;

endmodule

// File: tb/tb_overlay_blend_pipe.sv
// tb_overlay_blend_pipe: directed-vector bench for overlay_blend_pipe.
// Frames are streamed in, pixel outputs collected and compared.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL (`DTYPE_WIDTH'(1))
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START (`DTYPE_WIDTH'(2))
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END (`DTYPE_WIDTH'(3))
`endif

module tb_overlay_blend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [10:0] col_start, row_start, num_overlay_cols, num_overlay_rows;
    logic [7:0]  global_alpha;
    logic        key_enable;
    logic [23:0] key_value;
    logic [23:0] overlay_data;
    logic [7:0]  overlayA;
    logic        overlay_valid;
    logic        overlay_adv, overlay_restart, overlay_underflow;
    logic        dvi;
    logic [`DTYPE_WIDTH-1:0] dtypei, dtypeo;
    logic [23:0] datai, datao;
    logic [15:0] meta_datai, meta_datao;
    logic        dvo;

    always #5 clk = ~clk;

    overlay_blend_pipe dut (
        .clk(clk), .reset(reset), .enable(enable),
        .col_start(col_start), .row_start(row_start),
        .num_overlay_cols(num_overlay_cols),
        .num_overlay_rows(num_overlay_rows),
        .global_alpha(global_alpha), .key_enable(key_enable),
        .key_value(key_value), .overlay_data(overlay_data),
        .overlayA(overlayA), .overlay_valid(overlay_valid),
        .overlay_adv(overlay_adv), .overlay_restart(overlay_restart),
        .overlay_underflow(overlay_underflow),
        .dvi(dvi), .dtypei(dtypei), .datai(datai),
        .meta_datai(meta_datai), .dvo(dvo), .dtypeo(dtypeo),
        .datao(datao), .meta_datao(meta_datao)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [23:0] obs[$];
    int adv_cnt = 0;
    int rst_cnt = 0;

    always @(negedge clk) begin
        if (dvo && dtypeo == `DTYPE_PIXEL) obs.push_back(datao);
        if (overlay_adv) adv_cnt++;
        if (overlay_restart) rst_cnt++;
    end

    logic [23:0] base_px;
    logic        drop_en, chg_en;
    int          drop_r, drop_c, chg_row;
    logic [10:0] chg_col;

    task automatic word(input logic [`DTYPE_WIDTH-1:0] dt,
                        input logic [23:0] d);
        dvi = 1'b1;
        dtypei = dt;
        datai = d;
        meta_datai = meta_datai + 16'd1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        dvi = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int nr, input int nc);
        word(`DTYPE_FRAME_START, 24'h0);
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                overlay_valid = !(drop_en && r == drop_r && c == drop_c);
                if (chg_en && r == chg_row && c == 0) col_start = chg_col;
                word(`DTYPE_PIXEL, base_px);
            end
            overlay_valid = 1'b1;
            word(`DTYPE_ROW_END, 24'h0);
        end
        idle(3);
    endtask

    task automatic check_frame(input string tag, input int start,
                               input int nr, input int nc,
                               input int rs, input int cs,
                               input int wr, input int wc,
                               input logic [23:0] wv);
        int idx;
        logic [23:0] got, exp;
        chk({tag, " count"}, obs.size() - start, nr * nc);
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                idx = start + r * nc + c;
                got = (idx < obs.size()) ? obs[idx] : 24'hxxxxxx;
                exp = base_px;
                if (r >= rs && r < rs + wr && c >= cs && c < cs + wc
                    && !(drop_en && r == drop_r && c == drop_c))
                    exp = wv;
                chk($sformatf("%s r%0d c%0d", tag, r, c), got, exp);
            end
        end
    endtask

    task automatic win(input int rs, input int cs, input int wr,
                       input int wc);
        row_start = 11'(rs);
        col_start = 11'(cs);
        num_overlay_rows = 11'(wr);
        num_overlay_cols = 11'(wc);
    endtask

    int s, a0, r0;

    initial begin
        reset = 1'b1; enable = 1'b0; dvi = 1'b0;
        dtypei = '0; datai = '0; meta_datai = '0;
        win(0, 0, 4, 8);
        global_alpha = 8'hFF; key_enable = 1'b0; key_value = '0;
        overlay_data = 24'hAABBCC; overlayA = 8'hFF;
        overlay_valid = 1'b1;
        base_px = 24'h112233;
        drop_en = 1'b0; drop_r = 0; drop_c = 0;
        chg_en = 1'b0; chg_row = 0; chg_col = '0;

        repeat (3) @(negedge clk);
        chk("rst dvo", dvo, 0);
        chk("rst datao", datao, 0);
        chk("rst adv", overlay_adv, 0);
        chk("rst restart", overlay_restart, 0);
        chk("rst underflow", overlay_underflow, 0);
        reset = 1'b0;
        idle(2);

        // Latency: single pixel, passthrough
        dvi = 1'b1; dtypei = `DTYPE_PIXEL;
        datai = 24'h112233; meta_datai = 16'hABCD;
        @(negedge clk);
        chk("lat dvo@1", dvo, 0);
        dvi = 1'b0;
        @(negedge clk);
        chk("lat dvo@2", dvo, 1);
        chk("lat datao", datao, 24'h112233);
        chk("lat meta", meta_datao, 16'hABCD);
        chk("lat dtype", dtypeo, `DTYPE_PIXEL);
        @(negedge clk);
        chk("lat dvo@3", dvo, 0);

        // Passthrough with enable=0
        s = obs.size(); a0 = adv_cnt; r0 = rst_cnt;
        frame(4, 8);
        check_frame("pass", s, 4, 8, 0, 0, 0, 0, 24'h0);
        chk("pass adv", adv_cnt - a0, 0);
        chk("pass restart", rst_cnt - r0, 0);

        // Opaque window
        enable = 1'b1;
        win(1, 2, 2, 3);
        s = obs.size(); a0 = adv_cnt; r0 = rst_cnt;
        frame(4, 8);
        check_frame("opaque", s, 4, 8, 1, 2, 2, 3, 24'hAABBCC);
        chk("opaque adv", adv_cnt - a0, 6);
        chk("opaque restart", rst_cnt - r0, 1);

        // Rounding
        base_px = 24'h000000; overlay_data = 24'hFFFFFF;
        overlayA = 8'h80; win(0, 0, 1, 2);
        s = obs.size();
        frame(1, 2);
        check_frame("round ga=ff", s, 1, 2, 0, 0, 1, 2, 24'h808080);
        global_alpha = 8'h80;
        s = obs.size();
        frame(1, 2);
        check_frame("round ga=80", s, 1, 2, 0, 0, 1, 2, 24'h404040);
        global_alpha = 8'hFF; overlayA = 8'hFF;

        // Colour key
        base_px = 24'h112233; win(1, 2, 2, 3);
        key_enable = 1'b1; key_value = 24'h00FF00;
        overlay_data = 24'h00FF00;
        s = obs.size(); a0 = adv_cnt;
        frame(4, 8);
        check_frame("keyed", s, 4, 8, 0, 0, 0, 0, 24'h0);
        chk("keyed adv", adv_cnt - a0, 6);
        overlay_data = 24'h00FF01;
        s = obs.size();
        frame(4, 8);
        check_frame("unkeyed", s, 4, 8, 1, 2, 2, 3, 24'h00FF01);
        key_enable = 1'b0;

        // Underflow
        overlay_data = 24'hAABBCC;
        drop_en = 1'b1; drop_r = 1; drop_c = 3;
        s = obs.size(); a0 = adv_cnt;
        frame(4, 8);
        check_frame("uflow", s, 4, 8, 1, 2, 2, 3, 24'hAABBCC);
        chk("uflow adv", adv_cnt - a0, 5);
        chk("uflow sticky", overlay_underflow, 1);
        drop_en = 1'b0;
        word(`DTYPE_FRAME_START, 24'h0);
        idle(1);
        chk("uflow clear", overlay_underflow, 0);

        // Mid-frame config change only lands next frame
        win(0, 2, 4, 3);
        chg_en = 1'b1; chg_row = 1; chg_col = 11'd5;
        s = obs.size();
        frame(4, 8);
        check_frame("shadow old", s, 4, 8, 0, 2, 4, 3, 24'hAABBCC);
        chg_en = 1'b0;
        s = obs.size();
        frame(4, 8);
        check_frame("shadow new", s, 4, 8, 0, 5, 4, 3, 24'hAABBCC);

        // Window clipped at right edge
        win(0, 6, 4, 5);
        s = obs.size();
        frame(4, 8);
        check_frame("clip", s, 4, 8, 0, 6, 4, 5, 24'hAABBCC);

        // Reset in the middle of a frame
        win(0, 0, 4, 8);
        word(`DTYPE_FRAME_START, 24'h0);
        word(`DTYPE_PIXEL, base_px);
        word(`DTYPE_PIXEL, base_px);
        reset = 1'b1; dvi = 1'b0;
        @(negedge clk);
        chk("mrst dvo", dvo, 0);
        chk("mrst datao", datao, 0);
        chk("mrst adv", overlay_adv, 0);
        reset = 1'b0;
        s = obs.size(); a0 = adv_cnt;
        word(`DTYPE_PIXEL, base_px);
        idle(3);
        chk("mrst count", obs.size() - s, 1);
        chk("mrst pass", (s < obs.size()) ? obs[s] : 24'hxxxxxx,
            24'h112233);
        chk("mrst adv cnt", adv_cnt - a0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
